vjtag_mem_bridge: RTL and testbench

//  Parametrised JTAG-to-memory bridge behind the Virtual JTAG instance, driven by its tdi/ir_in/virtual_state_* outputs.

---
 rtl/vjtag_mem_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_vjtag_mem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_mem_bridge.sv
// ---------------------------------------------------------------------------
// vjtag_mem_bridge
// Bridges a Virtual JTAG instance to a simple on-chip memory port so a host
// can load and dump buffer contents (e.g. downscaler image RAM) over JTAG.
// Everything runs in the tck domain.
//
// Instructions (ir_in): 0 BYPASS, 1 WRITE, 2 READ, 3 SETADDR, 4 STATUS.
// Any other code behaves as BYPASS and sets the sticky err flag on update-IR.
//
// Ports
//   tck, rst           clock, asynchronous active-high reset
//   tdi / tdo          serial data from / to the vJtag instance
//   ir_in / ir_out     current instruction / status captured on v_cir
//   v_cdr..v_uir       virtual_state_* strobes
//   mem_addr           memory address
//   mem_wdata, mem_we  write data and one-cycle write strobe
//   mem_re, mem_rdata  one-cycle read strobe; read data captured one tck later
//
// Build option
//   VJTAG_AUTOINC_EN   defined: addr increments after each WRITE/READ update.
//                      undefined: addr changes only through SETADDR, and each
//                      READ update re-reads the same location.
// ---------------------------------------------------------------------------
module vjtag_mem_bridge #(
    parameter int IR_W   = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tdi,
    output logic              tdo,
    input  logic [IR_W-1:0]   ir_in,
    output logic [IR_W-1:0]   ir_out,
    input  logic              v_cdr,
    input  logic              v_sdr,
    input  logic              v_udr,
    input  logic              v_cir,
    input  logic              v_uir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SR_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    localparam logic [IR_W-1:0] IR_WRITE   = IR_W'(1);
    localparam logic [IR_W-1:0] IR_READ    = IR_W'(2);
    localparam logic [IR_W-1:0] IR_SETADDR = IR_W'(3);
    localparam logic [IR_W-1:0] IR_STATUS  = IR_W'(4);

`ifdef VJTAG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic [SR_W-1:0]   sr_q, sr_d;
    logic              byp_q, byp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              err_q, err_d;
    logic              rd_vld_q, rd_vld_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [IR_W-1:0]   ir_out_q, ir_out_d;

    logic              is_bypass;
    logic              ir_invalid;
    int                dr_len;
    logic [SR_W-1:0]   lo_mask;
    logic [SR_W-1:0]   status_word;

    always_comb begin
        ir_invalid = (ir_in > IR_STATUS);
        is_bypass  = ir_invalid || (ir_in == '0);
        dr_len     = (ir_in == IR_SETADDR) ? ADDR_W : DATA_W;
        // Bits strictly below the entry point of tdi; anything above L stays 0.
        lo_mask    = (SR_W'(1) << (dr_len - 1)) - SR_W'(1);

        // Status word is DATA_W long: rd_vld on top, err below it, then addr LSBs.
        status_word = '0;
        if (DATA_W >= 3) begin
            status_word = SR_W'(addr_q) & ((SR_W'(1) << (DATA_W - 2)) - SR_W'(1));
        end
        status_word[DATA_W-1] = rd_vld_q;
        if (DATA_W >= 2) begin
            status_word[DATA_W-2] = err_q;
        end
    end

    always_comb begin
        sr_d        = sr_q;
        byp_d       = byp_q;
        addr_d      = addr_q;
        rd_buf_d    = rd_buf_q;
        err_d       = err_q;
        rd_vld_d    = rd_vld_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        ir_out_d    = ir_out_q;

        // Read data is taken on the edge that ends the mem_re cycle, so it is
        // in rd_buf two edges after the update and before the next capture-DR.
        if (mem_re_q) begin
            rd_buf_d = mem_rdata;
            rd_vld_d = 1'b1;
        end

        // Write address advances only after the strobe cycle so the write
        // lands at the address that was current when it was issued.
        if (mem_we_q && AUTOINC) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (v_cdr) begin
            case (ir_in)
                IR_READ:   sr_d = SR_W'(rd_buf_q);
                IR_STATUS: sr_d = status_word;
                IR_WRITE,
                IR_SETADDR: sr_d = '0;
                default:   sr_d = sr_q;
            endcase
        end else if (v_sdr) begin
            if (is_bypass) begin
                byp_d = tdi;
            end else begin
                sr_d = ((sr_q >> 1) & lo_mask) | (SR_W'(tdi) << (dr_len - 1));
            end
        end else if (v_udr) begin
            case (ir_in)
                IR_WRITE: begin
                    mem_wdata_d = sr_q[DATA_W-1:0];
                    mem_we_d    = 1'b1;
                end
                IR_SETADDR: begin
                    addr_d   = sr_q[ADDR_W-1:0];
                    rd_vld_d = 1'b0;
                    mem_re_d = 1'b1;
                end
                IR_READ: begin
                    if (AUTOINC) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    mem_re_d = 1'b1;
                end
                IR_STATUS: err_d = 1'b0;
                default: ;
            endcase
        end

        if (v_uir && ir_invalid) begin
            err_d = 1'b1;
        end

        if (v_cir) begin
            ir_out_d    = '0;
            ir_out_d[1] = err_q;
            ir_out_d[0] = rd_vld_q;
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            sr_q        <= '0;
            byp_q       <= 1'b0;
            addr_q      <= '0;
            rd_buf_q    <= '0;
            err_q       <= 1'b0;
            rd_vld_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            ir_out_q    <= '0;
        end else begin
            sr_q        <= sr_d;
            byp_q       <= byp_d;
            addr_q      <= addr_d;
            rd_buf_q    <= rd_buf_d;
            err_q       <= err_d;
            rd_vld_q    <= rd_vld_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            ir_out_q    <= ir_out_d;
        end
    end

    assign tdo       = is_bypass ? byp_q : sr_q[0];
    assign ir_out    = ir_out_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
module tb_vjtag_mem_bridge;

    logic        tck = 1'b0;
    logic        rst;
    logic        tdi;
    logic        tdo;
    logic [2:0]  ir_in;
    logic [2:0]  ir_out;
    logic        v_cdr, v_sdr, v_udr, v_cir, v_uir;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata;

`ifdef VJTAG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    vjtag_mem_bridge #(.IR_W(3), .DATA_W(8), .ADDR_W(16)) dut (
        .tck       (tck),
        .rst       (rst),
        .tdi       (tdi),
        .tdo       (tdo),
        .ir_in     (ir_in),
        .ir_out    (ir_out),
        .v_cdr     (v_cdr),
        .v_sdr     (v_sdr),
        .v_udr     (v_udr),
        .v_cir     (v_cir),
        .v_uir     (v_uir),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 tck = ~tck;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          write_cnt = 0;
    wr_t         wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] m_addr;
    logic [7:0]  exp_rd;
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;

    // Memory device model and write scoreboard consumer.
    always @(negedge tck) begin
        mem_rdata = mem_re ? mem[mem_addr] : 8'h00;
        if (mem_we) begin
            wr_t e;
            write_cnt++;
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_pulse: mem_we high %0d cycles in a row, required 1", 2);
            end
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = wq.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
            mem[mem_addr] = mem_wdata;
        end
        if (mem_re) begin
            checks++;
            if (prev_re) begin
                errors++;
                $display("FAIL re_pulse: mem_re high on consecutive cycles, required 1");
            end
        end
        prev_we = mem_we;
        prev_re = mem_re;
    end

    task automatic ir_scan(input logic [2:0] instr, output logic [2:0] cap);
        v_cir = 1'b1;
        @(negedge tck);
        v_cir = 1'b0;
        cap = ir_out;
        @(negedge tck);
        ir_in = instr;
        v_uir = 1'b1;
        @(negedge tck);
        v_uir = 1'b0;
        @(negedge tck);
    endtask

    task automatic dr_scan(input int len, input logic [31:0] din, input bit do_udr,
                           output logic [31:0] dout);
        dout  = '0;
        v_cdr = 1'b1;
        @(negedge tck);
        v_cdr = 1'b0;
        for (int i = 0; i < len; i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            v_sdr   = 1'b1;
            @(negedge tck);
        end
        v_sdr = 1'b0;
        tdi   = 1'b0;
        if (do_udr) begin
            v_udr = 1'b1;
            @(negedge tck);
            v_udr = 1'b0;
        end
        repeat (4) @(negedge tck);
    endtask

    task automatic do_setaddr(input logic [15:0] a);
        logic [2:0]  c;
        logic [31:0] o;
        ir_scan(3'd3, c);
        dr_scan(16, {16'h0, a}, 1'b1, o);
        m_addr = a;
        exp_rd = ref_mem[a];
    endtask

    task automatic do_write(input logic [7:0] d);
        logic [31:0] o;
        wq.push_back({m_addr, d});
        ref_mem[m_addr] = d;
        dr_scan(8, {24'h0, d}, 1'b1, o);
        checks++;
        if (o[7:0] !== 8'h00) begin
            errors++;
            $display("FAIL write_capture: shifted out %h, required 00", o[7:0]);
        end
        if (AUTOINC) m_addr = m_addr + 16'd1;
    endtask

    task automatic do_read();
        logic [31:0] o;
        logic [7:0]  e;
        rq.push_back(exp_rd);
        dr_scan(8, 32'h0, 1'b1, o);
        e = rq.pop_front();
        checks++;
        if (o[7:0] !== e) begin
            errors++;
            $display("FAIL read_data: shifted out %h, required %h", o[7:0], e);
        end
        if (AUTOINC) m_addr = m_addr + 16'd1;
        exp_rd = ref_mem[m_addr];
    endtask

    task automatic test_reset();
        rst = 1'b1; tdi = 1'b0; ir_in = 3'd0;
        v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0; v_cir = 1'b0; v_uir = 1'b0;
        repeat (2) @(negedge tck);
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL rst_tdo: got %b, required 0", tdo); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", mem_we); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_re: got %b, required 0", mem_re); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0000", mem_addr); end
        checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL rst_wdata: got %h, required 00", mem_wdata); end
        checks++; if (ir_out !== 3'h0) begin errors++; $display("FAIL rst_ir_out: got %h, required 0", ir_out); end
        rst = 1'b0;
        @(negedge tck);
        m_addr = 16'h0;
        exp_rd = 8'h00;
    endtask

    task automatic test_rst_midscan();
        logic [2:0] c;
        ir_scan(3'd7, c);
        do_setaddr(16'h0042);
        ir_scan(3'd0, c);
        v_cdr = 1'b1;
        @(negedge tck);
        v_cdr = 1'b0;
        tdi = 1'b1; v_sdr = 1'b1;
        @(negedge tck);
        checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL byp_shift: tdo=%b, required 1", tdo); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL mid_rst_tdo: got %b, required 0", tdo); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL mid_rst_addr: got %h, required 0000", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b, required 0", mem_we); end
        @(negedge tck);
        v_sdr = 1'b0; tdi = 1'b0; rst = 1'b0;
        @(negedge tck);
        ir_scan(3'd0, c);
        checks++; if (c !== 3'h0) begin errors++; $display("FAIL mid_rst_ir_out: got %h, required 0", c); end
        m_addr = 16'h0;
        exp_rd = 8'h00;
    endtask

    task automatic test_write();
        logic [2:0] c;
        do_setaddr(16'h0010);
        ir_scan(3'd1, c);
        do_write(8'hA5);
        do_write(8'h3C);
    endtask

    task automatic test_read();
        logic [2:0] c;
        mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C; ref_mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'h96; ref_mem[16'h0012] = 8'h96;
        do_setaddr(16'h0010);
        ir_scan(3'd2, c);
        checks++; if (c !== 3'b001) begin errors++; $display("FAIL rd_vld_capture: got %b, required 001", c); end
        do_read();
        do_read();
        do_read();
    endtask

    task automatic test_wrap();
        logic [2:0] c;
        do_setaddr(16'hFFFF);
        ir_scan(3'd1, c);
        do_write(8'h11);
        do_write(8'h22);
    endtask

    task automatic test_same_addr();
        logic [2:0] c;
        do_setaddr(16'h0005);
        ir_scan(3'd1, c);
        do_write(8'h01);
        do_write(8'h02);
    endtask

    task automatic test_err();
        logic [2:0]  c;
        logic [31:0] o;
        logic [7:0]  e;
        ir_scan(3'd7, c);
        ir_scan(3'd4, c);
        checks++; if (c !== 3'b011) begin errors++; $display("FAIL err_set: ir_out=%b, required 011", c); end
        rq.push_back({1'b1, 1'b1, m_addr[5:0]});
        dr_scan(8, 32'h0, 1'b1, o);
        e = rq.pop_front();
        checks++; if (o[7:0] !== e) begin errors++; $display("FAIL status_word: got %h, required %h", o[7:0], e); end
        ir_scan(3'd4, c);
        checks++; if (c !== 3'b001) begin errors++; $display("FAIL err_clear: ir_out=%b, required 001", c); end
    endtask

    task automatic test_bypass();
        logic [2:0]  c;
        logic [31:0] o;
        logic [7:0]  din;
        din = 8'b1011_0010;
        ir_scan(3'd0, c);
        dr_scan(8, {24'h0, din}, 1'b1, o);
        checks++;
        if (o[7:1] !== din[6:0]) begin
            errors++;
            $display("FAIL bypass: got %b, required %b", o[7:1], din[6:0]);
        end
    endtask

    task automatic test_abort();
        logic [2:0]  c;
        logic [31:0] o;
        int          wc;
        ir_scan(3'd1, c);
        wc = write_cnt;
        dr_scan(8, 32'hFF, 1'b0, o);
        repeat (3) @(negedge tck);
        checks++;
        if (write_cnt !== wc) begin
            errors++;
            $display("FAIL abort: writes=%0d, required %0d", write_cnt - wc, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_rst_midscan();
        test_write();
        test_read();
        test_wrap();
        test_same_addr();
        test_err();
        test_bypass();
        test_abort();
        for (int i = 0; i < 20 && wq.size() != 0; i++) @(negedge tck);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: %0d outstanding, required 0", wq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
